// File: rtl/phase_accumulator_mc.sv
// Multi-channel DDS phase accumulator with double-buffered tuning registers and a linear chirp FSM.
// Optional build macro PHASE_DITHER_EN (needs M > N): LFSR dither added below the truncated phase LSB.
module phase_accumulator_mc #(
   parameter int C  = 2,
   parameter int M  = 8,
   parameter int N  = 4,
   parameter int SW = 8,
   parameter int CW = (C > 1) ? $clog2(C) : 1
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [1:0]     mode,
   input  logic           wr_en,
   input  logic [CW-1:0]  wr_ch,
   input  logic [1:0]     wr_sel,
   input  logic [M-1:0]   wr_data,
   input  logic           update,
   input  logic           sweep_start,
   output logic [C*N-1:0] phase,
   output logic           valid,
   output logic           sweep_busy,
   output logic           sweep_done,
   output logic           update_err
);

   localparam logic [1:0] MODE_RUN   = 2'b00;
   localparam logic [1:0] MODE_CLEAR = 2'b10;

   localparam logic [1:0] SEL_FREQ  = 2'b00;
   localparam logic [1:0] SEL_POFF  = 2'b01;
   localparam logic [1:0] SEL_DELTA = 2'b10;
   localparam logic [1:0] SEL_STEPS = 2'b11;

   localparam int SWM = (SW < M) ? SW : M;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SWEEP = 1'b1
   } sweep_state_t;

   logic [M-1:0]   freq_sh_q   [C];
   logic [M-1:0]   poff_sh_q   [C];
   logic [M-1:0]   delta_sh_q  [C];
   logic [SW-1:0]  steps_sh_q;

   logic [M-1:0]   freq_act_q  [C];
   logic [M-1:0]   poff_act_q  [C];
   logic [M-1:0]   delta_act_q [C];
   logic [SW-1:0]  steps_act_q;

   logic [M-1:0]   acc_q       [C];
   logic [M-1:0]   dith_c      [C];
   logic [M-1:0]   sum_c       [C];

   sweep_state_t   state_q;
   logic [SW-1:0]  cnt_q;
   logic           busy_q;
   logic           done_q;
   logic           err_q;

   logic [C*N-1:0] phase_d;
   logic [C*N-1:0] phase_q;
   logic           valid_q;

   logic [SW-1:0]  steps_wdata;
   logic           ch_ok;
   logic           run;

   assign steps_wdata = SW'(wr_data[SWM-1:0]);
   assign ch_ok       = (int'(wr_ch) < C);
   assign run         = (mode == MODE_RUN);

   // Shadow bank: host writes never disturb the running datapath directly.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < C; k++) begin
            freq_sh_q[k]  <= '0;
            poff_sh_q[k]  <= '0;
            delta_sh_q[k] <= '0;
         end
         steps_sh_q <= '0;
      end else if (wr_en) begin
         if (wr_sel == SEL_STEPS) begin
            steps_sh_q <= steps_wdata;
         end else if (ch_ok) begin
            case (wr_sel)
               SEL_FREQ:  freq_sh_q[wr_ch]  <= wr_data;
               SEL_POFF:  poff_sh_q[wr_ch]  <= wr_data;
               SEL_DELTA: delta_sh_q[wr_ch] <= wr_data;
               default:   ;
            endcase
         end
      end
   end

   // Sweep FSM and active bank. Update transfers are refused while a sweep owns freq_act.
   //  state    | meaning
   //  ST_IDLE  | no sweep; update strobe may load the active bank
   //  ST_SWEEP | chirp in progress; freq_act steps by delta_act on each RUN cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         steps_act_q <= '0;
         for (int k = 0; k < C; k++) begin
            freq_act_q[k]  <= '0;
            poff_act_q[k]  <= '0;
            delta_act_q[k] <= '0;
         end
      end else begin
         done_q <= 1'b0;
         err_q  <= update & busy_q;
         if (update && !busy_q) begin
            steps_act_q <= steps_sh_q;
            for (int k = 0; k < C; k++) begin
               freq_act_q[k]  <= freq_sh_q[k];
               poff_act_q[k]  <= poff_sh_q[k];
               delta_act_q[k] <= delta_sh_q[k];
            end
         end
         case (state_q)
            ST_IDLE: begin
               if (sweep_start && (steps_act_q != '0)) begin
                  state_q <= ST_SWEEP;
                  cnt_q   <= steps_act_q;
                  busy_q  <= 1'b1;
               end
            end
            ST_SWEEP: begin
               if (run) begin
                  for (int k = 0; k < C; k++) begin
                     freq_act_q[k] <= freq_act_q[k] + delta_act_q[k];
                  end
                  cnt_q <= cnt_q - 1'b1;
                  if (cnt_q == SW'(1)) begin
                     state_q <= ST_IDLE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Accumulators see freq_act before any same-edge sweep increment.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < C; k++) acc_q[k] <= '0;
      end else if (run) begin
         for (int k = 0; k < C; k++) acc_q[k] <= acc_q[k] + freq_act_q[k];
      end else if (mode == MODE_CLEAR) begin
         for (int k = 0; k < C; k++) acc_q[k] <= '0;
      end
   end

`ifdef PHASE_DITHER_EN
   localparam int DW  = M - N;
   localparam int DWL = (DW < 16) ? DW : 16;

   logic [15:0] lfsr_q;
   logic [15:0] rot_c [C];

   // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr_q <= 16'hACE1;
      end else begin
         lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
      end
   end

   always_comb begin
      for (int k = 0; k < C; k++) begin
         rot_c[k]  = '0;
         dith_c[k] = '0;
         for (int b = 0; b < 16; b++) rot_c[k][(b + k) % 16] = lfsr_q[b];
         for (int b = 0; b < DWL; b++) dith_c[k][b] = rot_c[k][b];
      end
   end
`else
   always_comb begin
      for (int k = 0; k < C; k++) dith_c[k] = '0;
   end
`endif

   always_comb begin
      phase_d = '0;
      for (int k = 0; k < C; k++) begin
         sum_c[k] = acc_q[k] + poff_act_q[k] + dith_c[k];
         phase_d[k*N +: N] = sum_c[k][M-1 -: N];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         phase_q <= '0;
         valid_q <= 1'b0;
      end else begin
         phase_q <= phase_d;
         valid_q <= run;
      end
   end

   assign phase      = phase_q;
   assign valid      = valid_q;
   assign sweep_busy = busy_q;
   assign sweep_done = done_q;
   assign update_err = err_q;

endmodule
